// File: rtl/draw_pkg.sv
// draw_pkg: shared definitions for the draw_* blocks.
//   - default VGA widths (x, y, colour)
//   - span FSM state encoding
//   - span orientation codes
package draw_pkg;

    localparam int unsigned DEF_X_W      = 8;
    localparam int unsigned DEF_Y_W      = 7;
    localparam int unsigned DEF_COLOUR_W = 18;

    localparam logic MODE_VERT = 1'b0;
    localparam logic MODE_HORZ = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width able to carry either axis.
    function automatic int unsigned max_w(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/span_counter.sv
// span_counter: walks an inclusive range lo..hi one step at a time.
//   clock, reset : clock and async active-low reset
//   load         : capture lo/hi, cur <= lo
//   en           : advance cur by one (never past hi)
//   lo, hi       : range bounds, lo <= hi
//   cur          : current position (registered)
//   last_c       : cur has reached hi (combinational)
module span_counter
    import draw_pkg::*;
#(
    parameter int unsigned W = DEF_X_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] lo,
    input  logic [W-1:0] hi,
    output logic [W-1:0] cur,
    output logic         last_c
);

    logic [W-1:0] hi_q;

    // Holding at hi lets hi = all-ones finish without wrapping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur  <= '0;
            hi_q <= '0;
        end else if (load) begin
            cur  <= lo;
            hi_q <= hi;
        end else if (en && (cur != hi_q)) begin
            cur  <= cur + W'(1);
        end
    end

    assign last_c = (cur == hi_q);

endmodule

// File: rtl/draw_span.sv
// draw_span: draws one inclusive vertical or horizontal run of pixels in one
// colour into the VGA adapter write port, honouring vga_ready backpressure.
//   clock, reset        : clock and async active-low reset
//   start / busy / done : sequencer handshake (start taken only in IDLE)
//   mode                : 0 = vertical (x fixed), 1 = horizontal (y fixed)
//   fix_coord           : fixed coordinate, truncated to the active axis
//   start_coord/end_coord : endpoints in either order
//   colour              : span colour
//   vga_x/vga_y/vga_colour/vga_write : registered pixel write
//   vga_ready           : adapter accepts the current pixel
// Optional: DRAW_SPAN_STIPPLE_EN adds an 8-bit pattern port; pixel i of the
// span is written only if pattern[i mod 8] is set.
module draw_span
    import draw_pkg::*;
#(
    parameter  int unsigned X_W      = DEF_X_W,
    parameter  int unsigned Y_W      = DEF_Y_W,
    parameter  int unsigned COLOUR_W = DEF_COLOUR_W,
    localparam int unsigned C_W      = max_w(X_W, Y_W)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    input  logic                mode,
    input  logic [C_W-1:0]      fix_coord,
    input  logic [C_W-1:0]      start_coord,
    input  logic [C_W-1:0]      end_coord,
    input  logic [COLOUR_W-1:0] colour,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_write,
    input  logic                vga_ready
`ifdef DRAW_SPAN_STIPPLE_EN
    ,
    input  logic [7:0]          pattern
`endif
);

    state_t         state, state_nxt;
    logic           mode_q;
    logic [C_W-1:0] fix_q;
    logic [C_W-1:0] lo_c, hi_c, cur, coord_c, fix_c;
    logic           mode_c, last_c, load_c, adv_c, step_c, pix_on_c, write_nxt;
    logic [X_W-1:0] x_c;
    logic [Y_W-1:0] y_c;

    // Endpoint ordering.
    assign lo_c = (start_coord <= end_coord) ? start_coord : end_coord;
    assign hi_c = (start_coord <= end_coord) ? end_coord : start_coord;

    span_counter #(.W(C_W)) u_cnt (
        .clock  (clock),
        .reset  (reset),
        .load   (load_c),
        .en     (adv_c),
        .lo     (lo_c),
        .hi     (hi_c),
        .cur    (cur),
        .last_c (last_c)
    );

    // A blanked (stippled-out) pixel moves on without waiting for the adapter.
    assign step_c = !vga_write || vga_ready;
    assign load_c = (state == IDLE) && start;
    assign adv_c  = (state == DRAW) && step_c && !last_c;

    // Pixel presented next: first pixel on load, successor on advance.
    assign coord_c = load_c ? lo_c : cur + C_W'(1);
    assign mode_c  = load_c ? mode : mode_q;
    assign fix_c   = load_c ? fix_coord : fix_q;
    assign x_c     = (mode_c == MODE_VERT) ? X_W'(fix_c) : X_W'(coord_c);
    assign y_c     = (mode_c == MODE_HORZ) ? Y_W'(fix_c) : Y_W'(coord_c);

`ifdef DRAW_SPAN_STIPPLE_EN
    logic [7:0]     pattern_q, pat_c;
    logic [C_W-1:0] lo_q, base_c;
    logic [2:0]     idx_c;

    // Pattern phase is relative to the low endpoint.
    assign pat_c    = load_c ? pattern : pattern_q;
    assign base_c   = load_c ? lo_c : lo_q;
    assign idx_c    = 3'(coord_c - base_c);
    assign pix_on_c = pat_c[idx_c];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pattern_q <= '0;
            lo_q      <= '0;
        end else if (load_c) begin
            pattern_q <= pattern;
            lo_q      <= lo_c;
        end
    end
`else
    assign pix_on_c = 1'b1;
`endif

    // Next-state and next write strobe.
    always_comb begin
        state_nxt = state;
        write_nxt = vga_write;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = DRAW;
                    write_nxt = pix_on_c;
                end
            end
            DRAW: begin
                if (step_c) begin
                    if (last_c) begin
                        state_nxt = DONE;
                        write_nxt = 1'b0;
                    end else begin
                        write_nxt = pix_on_c;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                write_nxt = 1'b0;
            end
        endcase
    end

    // State, span latches and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            vga_write  <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            mode_q     <= MODE_VERT;
            fix_q      <= '0;
        end else begin
            state     <= state_nxt;
            busy      <= (state_nxt != IDLE);
            done      <= (state_nxt == DONE);
            vga_write <= write_nxt;
            if (load_c) begin
                mode_q     <= mode;
                fix_q      <= fix_coord;
                vga_colour <= colour;
            end
            if (load_c || adv_c) begin
                vga_x <= x_c;
                vga_y <= y_c;
            end
        end
    end

endmodule

// File: tb/tb_draw_span.sv
// tb_draw_span: directed bench for draw_span with a pixel-list model.
module tb_draw_span;

    localparam int unsigned X_W      = 8;
    localparam int unsigned Y_W      = 7;
    localparam int unsigned COLOUR_W = 18;
    localparam int unsigned C_W      = 8;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                start = 1'b0;
    logic                mode  = 1'b0;
    logic                vga_ready = 1'b1;
    logic [C_W-1:0]      fix_coord = '0;
    logic [C_W-1:0]      start_coord = '0;
    logic [C_W-1:0]      end_coord = '0;
    logic [COLOUR_W-1:0] colour = '0;
    logic                busy, done, vga_write;
    logic [X_W-1:0]      vga_x;
    logic [Y_W-1:0]      vga_y;
    logic [COLOUR_W-1:0] vga_colour;
`ifdef DRAW_SPAN_STIPPLE_EN
    logic [7:0]          pattern = 8'hFF;
`endif

    typedef struct {
        int x;
        int y;
        int c;
    } pix_t;

    pix_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   exp_done = 0;
    int   done_seen = 0;

    always #5 clock = ~clock;

    draw_span dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .mode        (mode),
        .fix_coord   (fix_coord),
        .start_coord (start_coord),
        .end_coord   (end_coord),
        .colour      (colour),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .vga_write   (vga_write),
        .vga_ready   (vga_ready)
`ifdef DRAW_SPAN_STIPPLE_EN
        ,
        .pattern     (pattern)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Model: the ordered list of pixels the span must deliver.
    task automatic plan(input bit m, input int fix, input int s, input int e,
                        input int col, input int pat);
        int lo, hi;
        pix_t p;
        lo = (s < e) ? s : e;
        hi = (s < e) ? e : s;
        for (int v = lo; v <= hi; v++) begin
            if (((pat >> ((v - lo) % 8)) & 1) == 1) begin
                p.x = m ? (v % 256) : (fix % 256);
                p.y = m ? (fix % 128) : (v % 128);
                p.c = col;
                exp_q.push_back(p);
            end
        end
    endtask

    // Returns at posedge+1 of cycle 1 (start sampled at the end of cycle 0).
    task automatic launch(input bit m, input int fix, input int s, input int e,
                          input int col, input int pat, input bit completes);
        int eff_pat;
`ifdef DRAW_SPAN_STIPPLE_EN
        eff_pat = pat;
`else
        eff_pat = 8'hFF;
`endif
        plan(m, fix, s, e, col, eff_pat);
        if (completes) exp_done++;
        @(posedge clock);
        #1;
        mode        = m;
        fix_coord   = C_W'(fix);
        start_coord = C_W'(s);
        end_coord   = C_W'(e);
        colour      = COLOUR_W'(col);
`ifdef DRAW_SPAN_STIPPLE_EN
        pattern     = 8'(pat);
`endif
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    // Counts cycles from 1 until done; ready is low for the first ready_lo cycles.
    task automatic wait_done(input int ready_lo, input int limit, output int cyc, output int writes);
        bit seen;
        seen   = 1'b0;
        cyc    = 1;
        writes = 0;
        vga_ready = (ready_lo < 1);
        while (!seen && cyc <= limit) begin
            @(negedge clock);
            if (vga_write) writes++;
            if (done) seen = 1'b1;
            else begin
                @(posedge clock);
                #1;
                cyc++;
                vga_ready = (cyc > ready_lo);
            end
        end
        if (!seen) chk("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        int cyc, w;

        // Per-cycle compare of every presented pixel and every done pulse.
        fork
            forever begin
                @(negedge clock);
                if (reset) begin
                    if (vga_write) begin
                        if (exp_q.size() == 0) chk("write_unexpected", 64'd1, 64'd0);
                        else begin
                            chk("pix_x", vga_x, exp_q[0].x);
                            chk("pix_y", vga_y, exp_q[0].y);
                            chk("pix_colour", vga_colour, exp_q[0].c);
                            if (vga_ready) void'(exp_q.pop_front());
                        end
                    end
                    if (done) begin
                        done_seen++;
                        chk("done_queue_empty", exp_q.size(), 64'd0);
                        chk("done_busy", busy, 64'd1);
                    end
                end
            end
        join_none

        // Reset state
        #1 reset = 1'b0;
        #10;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_write", vga_write, 0);
        chk("rst_x", vga_x, 0);
        chk("rst_y", vga_y, 0);
        chk("rst_colour", vga_colour, 0);
        reset = 1'b1;

        // Vertical, in order
        launch(1'b0, 10, 5, 8, 18'h3F000, 8'hFF, 1'b1);
        chk("t1_model_size", exp_q.size(), 4);
        chk("t1_model_x0", exp_q[0].x, 10);
        chk("t1_model_y0", exp_q[0].y, 5);
        chk("t1_model_y3", exp_q[3].y, 8);
        chk("t1_busy", busy, 1);
        wait_done(0, 20, cyc, w);
        chk("t1_done_cycle", cyc, 5);
        chk("t1_writes", w, 4);
        @(posedge clock);
        #1;
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_done", done, 0);

        // Horizontal, reversed endpoints
        launch(1'b1, 20, 100, 97, 18'h00ABC, 8'hFF, 1'b1);
        chk("t2_model_x0", exp_q[0].x, 97);
        chk("t2_model_x3", exp_q[3].x, 100);
        chk("t2_model_y0", exp_q[0].y, 20);
        wait_done(0, 20, cyc, w);
        chk("t2_done_cycle", cyc, 5);
        chk("t2_writes", w, 4);

        // Single pixel, ready low for 3 cycles
        launch(1'b0, 7, 3, 3, 18'h12345, 8'hFF, 1'b1);
        wait_done(3, 20, cyc, w);
        chk("t3_done_cycle", cyc, 5);
        chk("t3_write_cycles", w, 4);

        // Full y range, no wrap
        launch(1'b0, 0, 0, 127, 18'h00001, 8'hFF, 1'b1);
        chk("t4_model_y127", exp_q[127].y, 127);
        wait_done(0, 300, cyc, w);
        chk("t4_done_cycle", cyc, 129);
        chk("t4_writes", w, 128);

        // Counter top at 2^C_W-1
        launch(1'b1, 5, 255, 250, 18'h20000, 8'hFF, 1'b1);
        chk("t5_model_x5", exp_q[5].x, 255);
        wait_done(0, 20, cyc, w);
        chk("t5_done_cycle", cyc, 7);
        chk("t5_writes", w, 6);

        // start held high through DRAW and DONE with different inputs: ignored
        launch(1'b0, 1, 0, 5, 18'h00111, 8'hFF, 1'b1);
        mode        = 1'b1;
        fix_coord   = 8'd50;
        start_coord = 8'd30;
        end_coord   = 8'd31;
        colour      = 18'h2AAAA;
        start       = 1'b1;
        wait_done(0, 20, cyc, w);
        chk("t6_done_cycle", cyc, 7);
        chk("t6_writes", w, 6);
        @(posedge clock);
        #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("t6_dropped_busy", busy, 0);
            chk("t6_dropped_write", vga_write, 0);
        end

        // Reset while pixel index 2 is presented
        launch(1'b0, 3, 0, 9, 18'h00155, 8'hFF, 1'b0);
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        chk("t7_pre_write", vga_write, 1);
        chk("t7_pre_y", vga_y, 2);
        reset = 1'b0;
        exp_q.delete();
        #1;
        chk("t7_abort_busy", busy, 0);
        chk("t7_abort_done", done, 0);
        chk("t7_abort_write", vga_write, 0);
        chk("t7_abort_x", vga_x, 0);
        chk("t7_abort_y", vga_y, 0);
        chk("t7_abort_colour", vga_colour, 0);
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("t7_after_busy", busy, 0);
            chk("t7_after_done", done, 0);
        end

`ifdef DRAW_SPAN_STIPPLE_EN
        // Stipple 0101 over 0..9
        launch(1'b0, 9, 0, 9, 18'h3FFFF, 8'b0000_0101, 1'b1);
        chk("t8_model_size", exp_q.size(), 3);
        chk("t8_model_y1", exp_q[1].y, 2);
        chk("t8_model_y2", exp_q[2].y, 8);
        wait_done(0, 30, cyc, w);
        chk("t8_done_cycle", cyc, 11);
        chk("t8_writes", w, 3);
`endif

        @(posedge clock);
        #1;
        chk("done_pulses", done_seen, exp_done);
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/draw_span.md
Name: draw_span

Overview:
- Parametrised successor of the single-column line drawer.
- Draws one inclusive run of pixels, either vertical (column) or horizontal (row), in a single colour.
- Honours VGA-side backpressure through vga_ready and accepts endpoints in either order.
- Sits between the renderer sequencer (start/done handshake) and the VGA adapter write port.

Parameters:
- X_W, 8, width of the VGA x coordinate.
- Y_W, 7, width of the VGA y coordinate.
- COLOUR_W, 18, colour width.
- Derived localparam C_W = max(X_W, Y_W), width of all coordinate inputs and the internal counter.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  request a span; sampled only in IDLE.
- busy  out  1  high in DRAW and DONE.
- done  out  1  one-cycle pulse when the span is complete.
- mode  in  1  0 = vertical (x fixed, y varies); 1 = horizontal (y fixed, x varies).
- fix_coord  in  C_W  fixed coordinate; truncated to X_W (vertical) or Y_W (horizontal).
- start_coord  in  C_W  first endpoint of the varying coordinate.
- end_coord  in  C_W  second endpoint of the varying coordinate.
- colour  in  COLOUR_W  span colour.
- vga_x  out  X_W  pixel x.
- vga_y  out  Y_W  pixel y.
- vga_colour  out  COLOUR_W  pixel colour.
- vga_write  out  1  pixel valid.
- vga_ready  in  1  adapter accepts the current pixel this cycle.

Behaviour:
- Reset (async, reset=0): state IDLE. busy, done, vga_write, vga_x, vga_y, vga_colour and the internal counter all become 0.
- The FSM has three states: IDLE, DRAW and DONE.
- IDLE, start=1:
  - Latch mode, fix_coord, colour, lo=min(start_coord,end_coord) and hi=max(start_coord,end_coord).
  - Set cur=lo and go to DRAW.
  - Equal endpoints give a one-pixel span.
- DRAW:
  - vga_write=1.
  - vga_x/vga_y are driven from the latched fixed coordinate and cur, truncated per mode, as registered outputs.
  - vga_colour holds the latched colour.
- Pixel transfer: a pixel transfers in any DRAW cycle with vga_ready=1.
  - If cur==hi, go to DONE; vga_write is 0 from the next cycle.
  - Otherwise cur<=cur+1 and the outputs update next cycle.
- Stall: with vga_ready=0, state, cur and all vga_* outputs hold stable.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency with vga_ready held high: start sampled at cycle 0; first write at cycle 1; N pixels occupy cycles 1..N; done at cycle N+1.
- start outside IDLE is ignored and not queued. start high in the DONE cycle is also dropped; a new span can only be taken from IDLE.
- Input changes after the start cycle have no effect on the current span.
- Wrap-around: the counter never exceeds hi, so hi = 2^C_W-1 terminates without overflow.
- Truncation: endpoints beyond the active axis width are truncated and are not clipped. The caller guarantees range.
- Reset mid-span: immediate abort, no done pulse.

Optional Feature:
- Macro: DRAW_SPAN_STIPPLE_EN.
- With the macro: an extra port pattern (in, 8) is latched at start.
  - Pixel index i = cur-lo is written only if pattern[i mod 8] = 1.
  - Skipped pixels spend one DRAW cycle with vga_write=0, ignore vga_ready and advance cur.
  - done timing is unchanged when vga_ready is held high.
- Without the macro: no pattern port; every pixel is written.

Decomposition:
- Shared package draw_pkg holds:
  - state encoding: IDLE=2'd0, DRAW=2'd1, DONE=2'd2;
  - MODE_VERT=1'b0 and MODE_HORZ=1'b1;
  - the default widths 8/7/18, also reused by the other draw_* blocks.
- One natural sub-module, span_counter: load lo/hi, advance on enable, and flag last when cur==hi. It is reusable by a future rectangle filler.
- The min/max ordering stays inline.

Test Plan:
- Vertical span, in order: mode=0, fix=10, start=5, end=8, colour=18'h3F000, ready=1.
  - Expect writes at (10,5),(10,6),(10,7),(10,8) on cycles 1-4.
  - Expect done on cycle 5.
- Horizontal span, reversed endpoints: mode=1, fix=20, start=100, end=97.
  - Expect writes at x=97..100 with y=20, in ascending order.
  - Expect one done pulse.
- Single pixel with backpressure: start=end=3, vga_ready low for 3 cycles.
  - Expect vga_write and (x,3) held for 4 cycles.
  - Expect done one cycle after ready rises.
- Boundary: mode=0, start=0, end=127 (Y_W=7).
  - Expect 128 writes with no wrap.
  - Expect done on cycle 129.
- Abort and ignore: reset low while drawing pixel 2.
  - Expect all outputs 0 immediately and no done.
  - Separately, start pulsed while busy: expect it ignored and the current span unchanged.
- Stipple, with DRAW_SPAN_STIPPLE_EN: pattern=8'b0000_0101, span 0..9, ready=1.
  - Expect vga_write only at indices 0, 2 and 8.
  - Expect done on cycle 11.
